ntt_ctrl: RTL and testbench
===========================

Name: ntt_ctrl

Overview:
- Sequencer for the in-place iterative Cooley-Tukey negacyclic NTT over an N-point coefficient RAM.
- Walks every stage, group and butterfly. Drives the dual-port RAM read addresses and the twiddle (psi) ROM address, with psi stored in bit-reversed order. Drives the matching write-back addresses after the butterfly pipeline latency.
- Sits between the top-level start/done handshake and the butterfly datapath. Contains no arithmetic on coefficients.

Parameters:
- N, 16, transform length; power of two.
- LOGN, 4, log2(N); also width of all address ports.
- BF_LAT, 3, cycles from read issue to write-back of the same butterfly; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a transform; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done is asserted.
- done  out  1  single-cycle completion pulse.
- rd_en  out  1  a butterfly read is issued this cycle.
- rd_addr_a  out  LOGN  upper-leg read address (j).
- rd_addr_b  out  LOGN  lower-leg read address (j+t).
- psi_addr  out  LOGN  twiddle ROM address, valid with rd_en.
- wr_en  out  1  write-back strobe.
- wr_addr_a  out  LOGN  write address for U+V*S.
- wr_addr_b  out  LOGN  write address for U-V*S.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0 every output is 0 and the FSM is in IDLE.
- Any reset mid-transform aborts immediately. No write occurs after reset deasserts until a new start.
- All outputs are registered.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 moves to RUN and clears the counters stage s=0 and butterfly k=0.
  - RUN: issues one butterfly per cycle. rd_en=1 and k increments.
  - RUN, on k=N/2-1: next state is DRAIN.
  - DRAIN: lasts exactly BF_LAT cycles with rd_en=0.
  - DRAIN exit: if s<LOGN-1, increment s, clear k, return to RUN. Otherwise go to DONE.
  - DONE: one cycle with done=1 and busy=0, then IDLE.
- Address generation for stage s and counter k:
  - t = N>>(s+1).
  - Group i = k>>(LOGN-1-s).
  - Offset o = k & (t-1).
  - rd_addr_a = (i<<(LOGN-s)) + o.
  - rd_addr_b = rd_addr_a + t.
  - psi_addr = (1<<s) + i.
  - All arithmetic is unsigned LOGN-bit. No wrap occurs for legal parameters.
- Write-back:
  - {rd_en, rd_addr_a, rd_addr_b} passes through a BF_LAT-deep shift register to produce {wr_en, wr_addr_a, wr_addr_b}.
  - The write of a butterfly issued at cycle c appears at cycle c+BF_LAT.
- Hazard rule: the first read of stage s+1 occurs exactly one cycle after the last write of stage s. The RAM never sees a read of a location with a pending write.
- Timing, with start sampled at edge 0:
  - Stage s reads occupy cycles 1+s*(N/2+BF_LAT) through that value plus N/2-1.
  - done pulses at cycle 1+LOGN*(N/2+BF_LAT), which is 45 for the defaults.
  - busy falls in the same cycle done rises.
- start while busy or in DONE is ignored; it is neither queued nor restarts the transform.
- Each transform issues exactly LOGN*N/2 rd_en cycles and the same number of wr_en cycles.

Test Plan:
- Reset then idle: rst_n=0 then 1, start=0 for 20 cycles -> all outputs remain 0.
- Single transform with defaults, start pulsed at cycle 0:
  - cycle 1: rd (0,8) psi=1.
  - cycle 8: rd (7,15) psi=1.
  - cycle 12: rd (0,4) psi=2.
  - Exactly 32 rd_en and 32 wr_en cycles total.
  - done=1 only at cycle 45.
- Address spot-checks:
  - stage 1, k=4 -> rd (8,12) psi=3.
  - stage 2, k=5 -> rd (9,11) psi=6.
  - stage 3, k=7 -> rd (14,15) psi=15.
  - Each write pair matches its read pair exactly 3 cycles later.
- Hazard check: last stage-0 write at cycle 11, first stage-1 read at cycle 12. A scoreboard RAM model with real butterfly arithmetic produces the golden NTT result.
- start held high for the whole transform -> exactly one transform runs. A second starts only once IDLE is re-entered with start still high, i.e. first rd at cycle 47.
- Abort: rst_n pulsed low at cycle 20 -> outputs clear asynchronously. A subsequent start yields the full correct 45-cycle sequence.

Source files
------------

// File: rtl/ntt_ctrl.sv
// ntt_ctrl: address sequencer for an in-place Cooley-Tukey negacyclic NTT.
// Walks stages s and butterflies k, issuing one butterfly read per cycle,
// then waits BF_LAT cycles so the last write of a stage lands before the
// first read of the next one. The twiddle ROM holds psi in bit-reversed order.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start                   transform request, sampled only in IDLE
//   busy, done              status; done is a one-cycle pulse
//   rd_en, rd_addr_a/b      butterfly read strobe and leg addresses (j, j+t)
//   psi_addr                twiddle ROM address, valid with rd_en
//   wr_en, wr_addr_a/b      write-back strobe and addresses, BF_LAT after read
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one butterfly read per cycle for stage s
// DRAIN | BF_LAT cycles without reads so stage writes complete
// DONE  | one-cycle completion, then IDLE
module ntt_ctrl #(
    parameter int N      = 16,
    parameter int LOGN   = 4,
    parameter int BF_LAT = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [LOGN-1:0] psi_addr,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b
);

    localparam int SW = (LOGN > 1) ? $clog2(LOGN) : 1;
    localparam int KW = (LOGN > 1) ? LOGN - 1 : 1;
    localparam int DW = $clog2(BF_LAT + 1);
    localparam int PW = 2 * LOGN + 1;

    localparam logic [KW-1:0]   K_LAST   = KW'(N / 2 - 1);
    localparam logic [SW-1:0]   S_LAST   = SW'(LOGN - 1);
    localparam logic [DW-1:0]   D_LOAD   = DW'(BF_LAT - 1);
    localparam logic [LOGN-1:0] HALF_W   = LOGN'(N / 2);
    localparam logic [LOGN-1:0] LAST_W   = LOGN'(LOGN - 1);
    localparam logic [LOGN-1:0] LOGN_W   = LOGN'(LOGN);
    localparam logic [LOGN-1:0] ONE_W    = LOGN'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   s;
    logic [KW-1:0]   k;
    logic [DW-1:0]   drain_cnt;

    logic            busy_c, done_c, rd_c;
    logic [LOGN-1:0] addr_a_c, addr_b_c, psi_c;
    logic [LOGN-1:0] s_w, k_w, t_w, i_w, o_w, a_w;

    logic [PW-1:0]   pipe [BF_LAT];

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (k == K_LAST) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == '0) state_nxt = (s == S_LAST) ? DONE : RUN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // stage / butterfly / drain counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= '0;
            k         <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        s <= '0;
                        k <= '0;
                    end
                end
                RUN: begin
                    k <= k + 1'b1;
                    if (k == K_LAST) drain_cnt <= D_LOAD;
                end
                DRAIN: begin
                    if (drain_cnt != '0) begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end else if (s != S_LAST) begin
                        s <= s + 1'b1;
                        k <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // address generation: group i, offset o within the group, half-span t
    always_comb begin
        s_w = LOGN'(s);
        k_w = LOGN'(k);
        t_w = HALF_W >> s_w;
        i_w = k_w >> (LAST_W - s_w);
        o_w = k_w & (t_w - ONE_W);
        a_w = (i_w << (LOGN_W - s_w)) + o_w;
    end

    // output decode; registered below so every port comes from a flop
    always_comb begin
        busy_c   = (state == RUN) || (state == DRAIN);
        done_c   = (state == DONE);
        rd_c     = (state == RUN);
        addr_a_c = '0;
        addr_b_c = '0;
        psi_c    = '0;
        if (rd_c) begin
            addr_a_c = a_w;
            addr_b_c = a_w + t_w;
            psi_c    = (ONE_W << s_w) + i_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            psi_addr  <= '0;
            for (int i = 0; i < BF_LAT; i++) pipe[i] <= '0;
        end else begin
            busy      <= busy_c;
            done      <= done_c;
            rd_en     <= rd_c;
            rd_addr_a <= addr_a_c;
            rd_addr_b <= addr_b_c;
            psi_addr  <= psi_c;
            // write-back tracks the issued read by exactly BF_LAT cycles
            pipe[0]   <= {rd_en, rd_addr_a, rd_addr_b};
            for (int i = 1; i < BF_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign {wr_en, wr_addr_a, wr_addr_b} = pipe[BF_LAT-1];

endmodule

// File: tb/tb_ntt_ctrl.sv
module tb_ntt_ctrl;

    localparam int N      = 16;
    localparam int LOGN   = 4;
    localparam int BF_LAT = 3;
    localparam int HALF   = N / 2;
    localparam int SLOT   = HALF + BF_LAT;
    localparam int TOTAL  = 1 + LOGN * SLOT;
    localparam int NBF    = LOGN * HALF;
    localparam int Q      = 97;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            busy, done, rd_en, wr_en;
    logic [LOGN-1:0] rd_addr_a, rd_addr_b, psi_addr, wr_addr_a, wr_addr_b;

    ntt_ctrl #(.N(N), .LOGN(LOGN), .BF_LAT(BF_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .psi_addr(psi_addr),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int u;
        int v;
        int w;
    } bf_t;

    int  n_chk = 0;
    int  n_fail = 0;
    int  rel = -1;
    int  n_rd, n_wr;
    int  psi;
    int  psi_rev [N];
    int  bf_a [NBF];
    int  bf_b [NBF];
    int  bf_p [NBF];
    int  ram [N];
    int  orig [N];
    bf_t pend [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t (rel %0d): got %0h expected %0h", tag, $time, rel, got, exp);
        end
    endtask

    function automatic int modpow(input int b, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % Q;
        return r;
    endfunction

    function automatic int brv(input int x);
        int r = 0;
        for (int i = 0; i < LOGN; i++) if (x & (1 << i)) r |= 1 << (LOGN - 1 - i);
        return r;
    endfunction

    // output j of the bit-reversed negacyclic NTT is a(psi^(2*brv(j)+1))
    function automatic int golden(input int j);
        int acc = 0;
        int e = 2 * brv(j) + 1;
        for (int i = 0; i < N; i++) acc = (acc + orig[i] * modpow(psi, (e * i) % (2 * N))) % Q;
        return acc;
    endfunction

    function automatic void expect_at(input int r, output logic [3:0] ctl,
                                      output logic [11:0] rdv, output logic [7:0] wrv);
        int x, y, idx;
        logic b, d, re, we;
        b = (r >= 1) && (r < TOTAL);
        d = (r == TOTAL);
        re = 1'b0; we = 1'b0; rdv = '0; wrv = '0;
        if (r >= 1 && r < TOTAL) begin
            x = r - 1;
            if (x / SLOT < LOGN && x % SLOT < HALF) begin
                idx = (x / SLOT) * HALF + x % SLOT;
                re = 1'b1;
                rdv = {4'(bf_a[idx]), 4'(bf_b[idx]), 4'(bf_p[idx])};
            end
            y = r - 1 - BF_LAT;
            if (y >= 0 && y / SLOT < LOGN && y % SLOT < HALF) begin
                idx = (y / SLOT) * HALF + y % SLOT;
                we = 1'b1;
                wrv = {4'(bf_a[idx]), 4'(bf_b[idx])};
            end
        end
        ctl = {b, d, re, we};
    endfunction

    task automatic load_data();
        for (int i = 0; i < N; i++) begin
            ram[i]  = int'($urandom_range(0, Q - 1));
            orig[i] = ram[i];
        end
    endtask

    task automatic step();
        logic        st, idle_before;
        logic [3:0]  ectl;
        logic [11:0] erd;
        logic [7:0]  ewr;
        bf_t         e;
        int          vs;
        st = start;
        idle_before = (rel < 0) || (rel >= TOTAL);
        @(posedge clk); #1;
        if (rel >= 0) rel++;
        if (st && idle_before) begin
            rel = 0;
            load_data();
            n_rd = 0; n_wr = 0;
            pend.delete();
        end
        expect_at(rel, ectl, erd, ewr);
        check_val("ctl", {busy, done, rd_en, wr_en}, ectl);
        check_val("rd", {rd_addr_a, rd_addr_b, psi_addr}, erd);
        check_val("wr", {wr_addr_a, wr_addr_b}, ewr);
        if (rd_en) begin
            n_rd++;
            e.u = ram[rd_addr_a];
            e.v = ram[rd_addr_b];
            e.w = psi_rev[psi_addr];
            pend.push_back(e);
        end
        if (wr_en) begin
            n_wr++;
            check_val("wr_pending", pend.size() > 0, 1);
            if (pend.size() > 0) begin
                e = pend.pop_front();
                vs = (e.v * e.w) % Q;
                ram[wr_addr_a] = (e.u + vs) % Q;
                ram[wr_addr_b] = (e.u - vs + Q) % Q;
            end
        end
        if (rel == TOTAL) begin
            check_val("rd_count", n_rd, NBF);
            check_val("wr_count", n_wr, NBF);
            for (int j = 0; j < N; j++) check_val("ntt", ram[j], golden(j));
        end
    endtask

    task automatic abort_now();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_val("abort", {busy, done, rd_en, wr_en, rd_addr_a, rd_addr_b, psi_addr,
                            wr_addr_a, wr_addr_b}, 0);
        rel = -1;
        pend.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int idx, hold, ab_at, gap;
        logic do_ab;

        psi = 0;
        for (int g = 2; g < Q && psi == 0; g++) if (modpow(g, N) == Q - 1) psi = g;
        for (int m = 0; m < N; m++) psi_rev[m] = modpow(psi, brv(m));
        idx = 0;
        for (int s = 0; s < LOGN; s++) begin
            for (int i = 0; i < (1 << s); i++) begin
                for (int j = 2 * i * (N >> (s + 1)); j < 2 * i * (N >> (s + 1)) + (N >> (s + 1)); j++) begin
                    bf_a[idx] = j;
                    bf_b[idx] = j + (N >> (s + 1));
                    bf_p[idx] = (1 << s) + i;
                    idx++;
                end
            end
        end

        // reset, then idle
        repeat (3) @(posedge clk);
        #1;
        check_val("reset", {busy, done, rd_en, wr_en, rd_addr_a, rd_addr_b, psi_addr,
                            wr_addr_a, wr_addr_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) step();

        // single transform
        start = 1'b1; step(); start = 1'b0;
        repeat (50) step();

        // start held high: back-to-back transforms, second begins at rel 47
        start = 1'b1;
        repeat (100) step();
        start = 1'b0;
        repeat (50) step();

        // abort at cycle 20, then a clean transform
        start = 1'b1; step(); start = 1'b0;
        for (int g = 0; g < 60 && rel < 19; g++) step();
        check_val("abort_reach", rel, 19);
        abort_now();
        repeat (3) step();
        start = 1'b1; step(); start = 1'b0;
        repeat (50) step();

        // randomized start timing with occasional aborts
        for (int it = 0; it < 8; it++) begin
            gap   = int'($urandom_range(0, 5));
            hold  = int'($urandom_range(1, 60));
            do_ab = ($urandom_range(0, 2) == 0);
            ab_at = int'($urandom_range(2, 43));
            repeat (gap) step();
            start = 1'b1;
            for (int h = 0; h < hold; h++) begin
                step();
                if (do_ab && rel == ab_at) break;
            end
            start = 1'b0;
            if (do_ab) begin
                for (int g = 0; g < 60 && rel != ab_at; g++) step();
                check_val("abort_reach", rel, ab_at);
                abort_now();
            end else begin
                for (int g = 0; g < 60 && rel >= 0 && rel <= TOTAL; g++) step();
                check_val("idle_reach", (rel < 0) || (rel > TOTAL), 1);
            end
        end
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
